// File: rtl/line_fill_responder.sv
// line_fill_responder: fixed-latency line-fill memory model answering cache refills, with a backdoor preload port.
module line_fill_responder #(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_req,
    input  logic [31:0]  mem_addr,
    output logic [127:0] mem_data_out,
    output logic         mem_ready,
    output logic         mem_err,
    input  logic         load_en,
    input  logic [31:0]  load_addr,
    input  logic [127:0] load_data,
    output logic         busy,
    output logic [15:0]  req_count
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t             state, state_nx;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   idx;
    logic               in_rng;
    logic [127:0]       mem [DEPTH_LINES];
    logic               req_rng, load_rng, accept, capture;
    logic [IDX_W-1:0]   load_idx;
    logic [127:0]       rd_data;
    logic               unused_lsbs;
    assign unused_lsbs = ^{mem_addr[3:0], load_addr[3:0]};
    assign req_rng     = mem_addr[31:4+IDX_W] == '0;
    assign load_rng    = load_addr[31:4+IDX_W] == '0;
    assign load_idx    = load_addr[4+IDX_W-1:4];
    assign accept      = state == IDLE && mem_req;
    assign capture     = state == WAIT && cnt == 4'd1;
    // a load landing on the pending line at the capture edge wins over the stale array word
    assign rd_data     = (load_en && load_rng && load_idx == idx) ? load_data : mem[idx];
    assign mem_ready   = state == RESP;
    assign mem_err     = state == RESP && !in_rng;
    assign busy        = state != IDLE;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (mem_req ? WAIT : IDLE) :
                   (state == WAIT) ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            in_rng       <= 1'b0;
            mem_data_out <= '0;
            req_count    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx       <= mem_addr[4+IDX_W-1:4];
                in_rng    <= req_rng;
                cnt       <= 4'(LATENCY - 1);
                req_count <= req_count + 16'd1;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (capture)
                mem_data_out <= in_rng ? rd_data : '0;
        end
    end
    // storage survives reset; loads are simply blocked while it is asserted
    always_ff @(posedge clk) begin
        if (!rst && load_en && load_rng)
            mem[load_idx] <= load_data;
    end
endmodule

// File: tb/tb_line_fill_responder.sv
// tb_line_fill_responder: directed and random stimulus against a cycle-numbered reference model.
module tb_line_fill_responder;
    localparam int L = 4;
    logic         clk = 1'b0;
    logic         rst, mem_req, mem_ready, mem_err, load_en, busy;
    logic [31:0]  mem_addr, load_addr;
    logic [127:0] mem_data_out, load_data;
    logic [15:0]  req_count;
    int           tests = 0, fails = 0, cyc = 0;
    logic [127:0] mm [256];
    bit           has = 0, rng = 0;
    int           a = -100, idx = 0;
    logic [127:0] dout = '0;
    logic [15:0]  cnt = '0;

    line_fill_responder #(.DEPTH_LINES(256), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_err(mem_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy), .req_count(req_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One cycle: drive inputs, advance the model to the coming edge, clock, compare.
    task automatic step(input bit r, input bit req, input logic [31:0] ad,
                        input bit le, input logic [31:0] la, input logic [127:0] ld);
        bit er;
        rst = r; mem_req = req; mem_addr = ad; load_en = le; load_addr = la; load_data = ld;
        if (r) begin
            has = 0; cnt = '0; dout = '0;
        end else begin
            if (le && la[31:12] == 0) mm[la[11:4]] = ld;
            if (has && cyc == a + L - 1) dout = rng ? mm[idx] : '0;
            if (req && (!has || cyc > a + L)) begin
                has = 1; a = cyc; rng = ad[31:12] == 0; idx = int'(ad[11:4]); cnt = cnt + 16'd1;
            end
        end
        @(posedge clk); #1; cyc++;
        er = has && cyc == a + L;
        chk("ready", 128'(mem_ready), 128'(er));
        chk("err", 128'(mem_err), 128'(er && !rng));
        chk("busy", 128'(busy), 128'(has && cyc > a && cyc <= a + L));
        chk("data", mem_data_out, dout);
        chk("count", 128'(req_count), 128'(cnt));
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 32'h0, '0);
    endtask

    // Hold a request through its response, as the cache would.
    task automatic req_line(input logic [31:0] ad);
        repeat (L) step(0, 1, ad, 0, 32'h0, '0);
        idle();
    endtask

    function automatic logic [127:0] rdata();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] raddr();
        logic [31:0] r = $urandom;
        if ($urandom_range(3) == 0) return r;
        return {20'h0, 5'h0, 3'($urandom_range(7)), r[3:0]};
    endfunction

    initial begin
        step(1, 0, 32'h0, 0, 32'h0, '0);
        step(1, 1, 32'h30, 1, 32'h0, rdata());
        for (int i = 0; i < 256; i++)
            step(0, 0, 32'h0, 1, 32'(i) << 4, i == 3 ? 128'h0123456789ABCDEF0123456789ABCDEF : rdata());
        req_line(32'h0000_0030);
        req_line(32'h0000_1000);
        step(0, 1, 32'h50, 0, 32'h0, '0);
        step(0, 1, 32'h50, 0, 32'h0, '0);
        step(0, 1, 32'h50, 0, 32'h0, '0);
        step(0, 1, 32'h50, 1, 32'h50, {16{8'hAA}});
        idle();
        repeat (16) step(0, 1, raddr(), 0, 32'h0, '0);
        idle();
        step(0, 1, 32'h40, 0, 32'h0, '0);
        step(0, 0, 32'h40, 0, 32'h0, '0);
        step(1, 0, 32'h40, 0, 32'h0, '0);
        repeat (6) idle();
        step(1, 0, 32'h0, 0, 32'h0, '0);
        req_line(32'h0000_0060);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(63) == 0, $urandom_range(1) == 1, raddr(),
                 $urandom_range(2) == 0, raddr(), rdata());
        repeat (L + 2) idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
